blackjack_key_input: RTL

Front-end command source for `blackjackGame`: turns the two raw, bouncy, active-low board pushbuttons into clean, one-per-press game commands. It covers synchronization, per-key debounce and two-key chord detection. Commands are delivered through a valid/ready handshake, so a command is never lost while the game is busy. It sits between the board `KEY` pins and the game's command input; this is the producer end of the game's key interface.

---
 rtl/blackjack_key_input.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/blackjack_key_input.sv
// Pushbutton front end for the blackjack game: synchronizes and debounces the two
// active-low keys, detects a two-key chord and issues one command per press via valid/ready.
module blackjack_key_input #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CHORD_CYCLES    = 5000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] keys,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [1:0] cmd,
    output logic [1:0] keys_db
);

    localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned ChW = $clog2(CHORD_CYCLES + 1);
    localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DbW-1:0] DbMax  = '1;
    localparam logic [ChW-1:0] ChLast = ChW'(CHORD_CYCLES - 1);
    localparam logic [ChW-1:0] ChMax  = '1;

    localparam logic [1:0] CmdNone    = 2'b00;
    localparam logic [1:0] CmdHit     = 2'b01;
    localparam logic [1:0] CmdStand   = 2'b10;
    localparam logic [1:0] CmdNewGame = 2'b11;

    typedef enum logic [1:0] {StWaitRel, StIdle, StChord, StValid} state_e;

    logic [1:0]     sync1_q, sync1_d;
    logic [1:0]     sync2_q, sync2_d;
    logic [1:0]     db_q, db_d;
    logic [DbW-1:0] db_cnt_q [2];
    logic [DbW-1:0] db_cnt_d [2];
    state_e         state_q, state_d;
    logic           key_sel_q, key_sel_d;
    logic [ChW-1:0] ch_cnt_q, ch_cnt_d;
    logic           cmd_valid_q, cmd_valid_d;
    logic [1:0]     cmd_q, cmd_d;
    logic           settle_q, settle_d;

    logic [1:0]     level;
    logic [ChW-1:0] ch_cnt_inc;
    logic [1:0]     single_cmd;
    logic           quiet;

    assign level      = ~sync2_q;
    assign ch_cnt_inc = (ch_cnt_q == ChMax) ? ch_cnt_q : ch_cnt_q + ChW'(1);
    assign single_cmd = key_sel_q ? CmdStand : CmdHit;

    // Nothing pressed anywhere in the input pipeline, including pending debounce mismatches.
    assign quiet = (db_q == 2'b00) && (sync1_q == 2'b11) && (sync2_q == 2'b11) &&
                   (db_cnt_q[0] == '0) && (db_cnt_q[1] == '0);

    always_comb begin
        sync1_d  = keys;
        sync2_d  = sync1_q;
        db_d     = db_q;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (level[i] == db_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DbLast) begin
                db_d[i]     = ~db_q[i];
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] != DbMax) begin
                db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        key_sel_d   = key_sel_q;
        ch_cnt_d    = ch_cnt_q;
        cmd_valid_d = cmd_valid_q;
        cmd_d       = cmd_q;
        settle_d    = quiet;
        unique case (state_q)
            StWaitRel: begin
                // Quiet for two cycles, so a key held through reset is seen before leaving.
                if (quiet && settle_q) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (db_q == 2'b11) begin
                    state_d     = StValid;
                    cmd_valid_d = 1'b1;
                    cmd_d       = CmdNewGame;
                end else if (db_q != 2'b00) begin
                    state_d   = StChord;
                    key_sel_d = db_q[1];
                    ch_cnt_d  = '0;
                end
            end
            StChord: begin
                ch_cnt_d = ch_cnt_inc;
                if (db_q == 2'b11) begin
                    state_d     = StValid;
                    cmd_valid_d = 1'b1;
                    cmd_d       = CmdNewGame;
                end else if (!db_q[key_sel_q] || (ch_cnt_inc >= ChLast)) begin
                    state_d     = StValid;
                    cmd_valid_d = 1'b1;
                    cmd_d       = single_cmd;
                end
            end
            StValid: begin
                if (cmd_ready) begin
                    state_d     = StWaitRel;
                    cmd_valid_d = 1'b0;
                    cmd_d       = CmdNone;
                end
            end
            default: begin
                state_d     = StWaitRel;
                cmd_valid_d = 1'b0;
                cmd_d       = CmdNone;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= 2'b11;
            sync2_q     <= 2'b11;
            db_q        <= 2'b00;
            db_cnt_q[0] <= '0;
            db_cnt_q[1] <= '0;
            state_q     <= StWaitRel;
            key_sel_q   <= 1'b0;
            ch_cnt_q    <= '0;
            cmd_valid_q <= 1'b0;
            cmd_q       <= CmdNone;
            settle_q    <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            db_q        <= db_d;
            db_cnt_q[0] <= db_cnt_d[0];
            db_cnt_q[1] <= db_cnt_d[1];
            state_q     <= state_d;
            key_sel_q   <= key_sel_d;
            ch_cnt_q    <= ch_cnt_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_q       <= cmd_d;
            settle_q    <= settle_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd       = cmd_q;
    assign keys_db   = db_q;

endmodule
